clk_div_checker: RTL

CLK_DIV_CHECKER -- requirements
Module: clk_div_checker

---
 rtl/clk_div_checker.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/clk_div_checker.sv
// clk_div_checker: measures the period and high time of a divided clock (div_in) in clk cycles,
// compares each period against the expected ratio N, and reports lock, mismatches and timeouts.
//
// Ports:
//   clk         system clock, all state updates on its rising edge
//   rst         synchronous active-high reset, overrides every other input
//   en          measurement enable; low forces the checker idle
//   N           expected divide ratio (must be >= 2)
//   div_in      divided clock from the upstream divider, derived from clk
//   period      clk cycles between the last two rising edges of div_in
//   high_time   clk cycles div_in was high within that period
//   meas_valid  one-cycle pulse when period/high_time update
//   locked      LOCK_CNT consecutive periods matched N
//   err         one-cycle pulse on a period mismatch
//   err_cnt     saturating mismatch count
//   stuck       no rising edge for TMO cycles; clears on the next rise
//   cfg_err     N < 2, unsupported ratio
module clk_div_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TMO      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] N,
  input  logic       div_in,
  output logic [7:0] period,
  output logic [7:0] high_time,
  output logic       meas_valid,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       stuck,
  output logic       cfg_err
);

  localparam logic [7:0] TmoVal  = 8'(TMO);
  localparam logic [3:0] LockVal = 4'(LOCK_CNT);

  typedef enum logic [1:0] {StIdle, StSync, StMeasure, StLocked} state_e;

  state_e     state_q, state_d;
  logic       div_q, div_dly_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] n_q, n_d;
  logic [3:0] match_q, match_d, match_inc;
  logic [7:0] period_d, high_time_d, err_cnt_d;
  logic       meas_valid_d, locked_d, err_d, stuck_d, cfg_err_d;
  logic       rise, cfg_bad, n_change, is_match, tmo_hit, go_idle;

  // div_in is sampled twice; all measurement works on the first stage so the rise
  // detection and the counting see the same value.
  assign rise      = div_q & ~div_dly_q;
  assign cfg_bad   = (N < 8'd2);
  assign n_change  = (N != n_q);
  assign is_match  = (cnt_q == n_q);
  assign tmo_hit   = (cnt_q == TmoVal);
  assign go_idle   = ~en | cfg_bad;
  assign match_inc = (match_q == LockVal) ? match_q : match_q + 4'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Priority: disable/bad ratio, N change, rise, timeout.
  always_comb begin
    state_d = state_q;
    if (go_idle) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSync;
        StSync: begin
          if (n_change) begin
            state_d = StSync;
          end else if (rise) begin
            state_d = StMeasure;
          end
        end
        StMeasure, StLocked: begin
          if (n_change) begin
            state_d = StSync;
          end else if (rise) begin
            if (!is_match) begin
              state_d = StMeasure;
            end else if (match_inc == LockVal) begin
              state_d = StLocked;
            end
          end else if (tmo_hit) begin
            state_d = StSync;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and output next values, following the same priority as the FSM.
  always_comb begin
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    n_d          = n_q;
    match_d      = match_q;
    period_d     = period;
    high_time_d  = high_time;
    err_cnt_d    = err_cnt;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    locked_d     = locked;
    stuck_d      = stuck;
    cfg_err_d    = cfg_bad;

    if (go_idle) begin
      locked_d = 1'b0;
      match_d  = 4'd0;
      stuck_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: n_d = N;
        StSync: begin
          if (n_change) begin
            n_d = N;
          end else if (rise) begin
            // First edge only starts the count; there is no previous edge to measure from.
            cnt_d   = 8'd1;
            hcnt_d  = {7'd0, div_q};
            stuck_d = 1'b0;
          end
        end
        StMeasure, StLocked: begin
          if (n_change) begin
            n_d      = N;
            locked_d = 1'b0;
            match_d  = 4'd0;
          end else if (rise) begin
            period_d     = cnt_q;
            high_time_d  = hcnt_q;
            meas_valid_d = 1'b1;
            cnt_d        = 8'd1;
            hcnt_d       = {7'd0, div_q};
            stuck_d      = 1'b0;
            if (is_match) begin
              match_d = match_inc;
              if (match_inc == LockVal) begin
                locked_d = 1'b1;
              end
            end else begin
              err_d     = 1'b1;
              err_cnt_d = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
              match_d   = 4'd0;
              locked_d  = 1'b0;
            end
          end else if (tmo_hit) begin
            stuck_d  = 1'b1;
            locked_d = 1'b0;
            match_d  = 4'd0;
          end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (div_q && (hcnt_q != 8'hFF)) begin
              hcnt_d = hcnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= 1'b0;
      div_dly_q  <= 1'b0;
      cnt_q      <= 8'd0;
      hcnt_q     <= 8'd0;
      n_q        <= 8'd0;
      match_q    <= 4'd0;
      period     <= 8'd0;
      high_time  <= 8'd0;
      err_cnt    <= 8'd0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      stuck      <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      div_q      <= div_in;
      div_dly_q  <= div_q;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      n_q        <= n_d;
      match_q    <= match_d;
      period     <= period_d;
      high_time  <= high_time_d;
      err_cnt    <= err_cnt_d;
      meas_valid <= meas_valid_d;
      locked     <= locked_d;
      err        <= err_d;
      stuck      <= stuck_d;
      cfg_err    <= cfg_err_d;
    end
  end

endmodule
